// File: rtl/mult_disp_pkg.sv
// Shared definitions for the multiplier-to-7-segment display path.
// Segment codes are active-high, ordered {g,f,e,d,c,b,a}.
package mult_disp_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder.
// Ports:
//   bcd - BCD digit in; codes 10-15 decode to blank
//   seg - active-high segments {g,f,e,d,c,b,a}
module seg7_decode
  import mult_disp_pkg::*;
(
  input  bcd_t             bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mult_integrated_disp.sv
// Registered 4x4 unsigned multiplier with decimal 7-segment output.
// Product -> double-dabble BCD -> segment decode, one output register stage.
// Optional build macro MULT_DISP_LEADING_ZERO_BLANK_EN blanks leading zero
// digits (hundreds, then tens); the ones digit always displays.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset; outputs blank while low
//   Input1 - multiplicand A, 0-15
//   Input2 - multiplier B, 0-15
//   seg1   - ones digit segments
//   seg2   - tens digit segments
//   seg3   - hundreds digit segments
module mult_integrated_disp
  import mult_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       Input1,
  input  logic [3:0]       Input2,
  output logic [SEG_W-1:0] seg1,
  output logic [SEG_W-1:0] seg2,
  output logic [SEG_W-1:0] seg3
);

  logic [7:0] prod;
  bcd_t       ones, tens, hunds;
  logic [SEG_W-1:0] dec_ones, dec_tens, dec_hunds;
  logic [SEG_W-1:0] seg1_d, seg2_d, seg3_d;

  // 15*15 = 225 fits in 8 bits, no overflow possible.
  assign prod = Input1 * Input2;

  // Double-dabble: {hunds, tens, ones, binary} shifted left 8 times,
  // adding 3 to any BCD nibble >= 5 before each shift.
  always_comb begin
    logic [19:0] dd;
    dd = {12'd0, prod};
    for (int i = 0; i < 8; i++) begin
      if (dd[11:8]  >= 4'd5) dd[11:8]  = dd[11:8]  + 4'd3;
      if (dd[15:12] >= 4'd5) dd[15:12] = dd[15:12] + 4'd3;
      if (dd[19:16] >= 4'd5) dd[19:16] = dd[19:16] + 4'd3;
      dd = dd << 1;
    end
    ones  = dd[11:8];
    tens  = dd[15:12];
    hunds = dd[19:16];
  end

  seg7_decode u_dec_ones (
    .bcd (ones),
    .seg (dec_ones)
  );

  seg7_decode u_dec_tens (
    .bcd (tens),
    .seg (dec_tens)
  );

  seg7_decode u_dec_hunds (
    .bcd (hunds),
    .seg (dec_hunds)
  );

`ifdef MULT_DISP_LEADING_ZERO_BLANK_EN
  always_comb begin
    seg1_d = dec_ones;
    seg2_d = dec_tens;
    seg3_d = dec_hunds;
    if (hunds == 4'd0) begin
      seg3_d = SEG_BLANK;
      if (tens == 4'd0) seg2_d = SEG_BLANK;
    end
  end
`else
  always_comb begin
    seg1_d = dec_ones;
    seg2_d = dec_tens;
    seg3_d = dec_hunds;
  end
`endif

  // All three digits update together so a product is never split across edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg1 <= SEG_BLANK;
      seg2 <= SEG_BLANK;
      seg3 <= SEG_BLANK;
    end else begin
      seg1 <= seg1_d;
      seg2 <= seg2_d;
      seg3 <= seg3_d;
    end
  end

endmodule

// File: tb/tb_mult_integrated_disp.sv
module tb_mult_integrated_disp;

  logic       clk;
  logic       rst_n;
  logic [3:0] Input1, Input2;
  logic [6:0] seg1, seg2, seg3;

  int checks;
  int failures;

  mult_integrated_disp dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Input1 (Input1),
    .Input2 (Input2),
    .seg1   (seg1),
    .seg2   (seg2),
    .seg3   (seg3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got {seg3,seg2,seg1}=%b_%b_%b expected %b_%b_%b", tag,
               obs[20:14], obs[13:7], obs[6:0], exp[20:14], exp[13:7], exp[6:0]);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Reference: decimal digits by division, then display rule.
  function automatic logic [20:0] model(input int a, input int b);
    int p, h, t, o;
    logic [6:0] s1, s2, s3;
    p = a * b;
    h = p / 100;
    t = (p % 100) / 10;
    o = p % 10;
    s1 = enc(o);
    s2 = enc(t);
    s3 = enc(h);
`ifdef MULT_DISP_LEADING_ZERO_BLANK_EN
    if (h == 0) begin
      s3 = 7'b0;
      if (t == 0) s2 = 7'b0;
    end
`endif
    return {s3, s2, s1};
  endfunction

  function automatic logic [20:0] outs();
    return {seg3, seg2, seg1};
  endfunction

  localparam logic [20:0] BLANK = 21'd0;

  logic [20:0] prev_exp;

  // Drive on the falling edge, confirm no change before the rising edge,
  // then check one step after the rising edge.
  task automatic apply(input int a, input int b, input string tag);
    @(negedge clk);
    Input1 = 4'(a);
    Input2 = 4'(b);
    #1;
    check({tag, "_hold"}, outs(), prev_exp);
    @(posedge clk);
    #1;
    prev_exp = model(a, b);
    check(tag, outs(), prev_exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n  = 1'b1;
    Input1 = 4'd15;
    Input2 = 4'd15;
    #1;
    rst_n = 1'b0;
    #2;
    check("reset_blank", outs(), BLANK);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_225", outs(), {7'b1011011, 7'b1011011, 7'b1101101});
    prev_exp = {7'b1011011, 7'b1011011, 7'b1101101};

    apply(7, 9, "p63");
`ifdef MULT_DISP_LEADING_ZERO_BLANK_EN
    check("p63_const", outs(), {7'b0000000, 7'b1111101, 7'b1001111});
`else
    check("p63_const", outs(), {7'b0111111, 7'b1111101, 7'b1001111});
`endif
    apply(10, 10, "p100");
    check("p100_const", outs(), {7'b0000110, 7'b0111111, 7'b0111111});
    apply(0, 0, "p0");
`ifdef MULT_DISP_LEADING_ZERO_BLANK_EN
    check("p0_const", outs(), {7'b0000000, 7'b0000000, 7'b0111111});
`else
    check("p0_const", outs(), {7'b0111111, 7'b0111111, 7'b0111111});
`endif
    apply(1, 5, "p5");
    apply(15, 14, "p210");

    // Exhaustive sweep, new pair every cycle.
    for (int i = 0; i < 256; i++) begin
      Input1 = 4'(i / 16);
      Input2 = 4'(i % 16);
      @(posedge clk);
      #1;
      check("sweep", outs(), model(i / 16, i % 16));
      if (i == 100) begin
        // Mid-stream reset pulse of half a cycle.
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_blank", outs(), BLANK);
        Input1 = 4'd13;
        Input2 = 4'd11;
        #4;
        rst_n = 1'b1;
        #1;
        check("mid_reset_still_blank", outs(), BLANK);
        @(posedge clk);
        #1;
        check("mid_reset_release", outs(), model(13, 11));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
